// File: rtl/fp_pkg.sv
// Shared types and constants for the multi-cycle single-precision add/multiply unit.
package fp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_EXEC,
    S_NORM,
    S_DONE
  } state_t;

  localparam logic signed [9:0] BIAS    = 10'sd127;
  localparam logic        [7:0] EXP_MAX = 8'd255;
  localparam logic       [31:0] QNAN    = 32'h7FC00000;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

endpackage

// File: rtl/fp_lzc.sv
// Combinational 48-bit leading-zero counter; an all-zero input reports 48.
module fp_lzc (
  input  logic [47:0] value,
  output logic [5:0]  count
);

  // Scan upward so the highest set bit is the last (winning) assignment.
  always_comb begin
    count = 6'd48;
    for (int i = 0; i < 48; i++) begin
      if (value[i]) count = 6'(47 - i);
    end
  end

endmodule

// File: rtl/fp_mc_unit.sv
// Multi-cycle IEEE-754 single-precision adder/multiplier: IDLE -> UNPACK -> EXEC -> NORM -> DONE.
// Truncating rounding, subnormals flushed to zero, a single canonical quiet NaN.
module fp_mc_unit
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ALUControl,
  output logic        busy,
  output logic        done,
  output logic [31:0] Result
);

  state_t state, state_nxt;

  logic [31:0] a_q, b_q;
  logic        op_q;

  logic        sa_q, sb_q;
  logic [7:0]  ea_q, eb_q;
  logic [23:0] ma_q, mb_q;

  logic               x_sign_q;
  logic signed [9:0]  x_exp_q;
  logic [47:0]        x_mant_q;
  logic               x_special_q;
  logic [31:0]        x_spec_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE:   if (start) state_nxt = S_UNPACK;
      S_UNPACK: begin busy = 1'b1; state_nxt = S_EXEC; end
      S_EXEC:   begin busy = 1'b1; state_nxt = S_NORM; end
      S_NORM:   begin busy = 1'b1; state_nxt = S_DONE; end
      S_DONE:   begin busy = 1'b1; done = 1'b1; state_nxt = S_IDLE; end
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= 1'b0;
    end else if (state == S_IDLE && start) begin
      a_q  <= a;
      b_q  <= b;
      op_q <= ALUControl;
    end
  end

  // A zero exponent drops the hidden bit, so subnormals behave as zero downstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sa_q <= 1'b0;
      sb_q <= 1'b0;
      ea_q <= '0;
      eb_q <= '0;
      ma_q <= '0;
      mb_q <= '0;
    end else if (state == S_UNPACK) begin
      sa_q <= a_q[31];
      sb_q <= b_q[31];
      ea_q <= a_q[30:23];
      eb_q <= b_q[30:23];
      ma_q <= (a_q[30:23] == 8'd0) ? 24'd0 : {1'b1, a_q[22:0]};
      mb_q <= (b_q[30:23] == 8'd0) ? 24'd0 : {1'b1, b_q[22:0]};
    end
  end

  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_larger;
  logic        sign_l;
  logic [7:0]  exp_l, exp_s, exp_diff;
  logic [23:0] m_l, m_s;
  logic [47:0] s_aligned, product;
  logic [48:0] sum;
  logic               e_sign, e_special;
  logic signed [9:0]  e_exp;
  logic [47:0]        e_mant;
  logic [31:0]        e_spec;

  always_comb begin
    a_nan    = (ea_q == EXP_MAX) && (ma_q[22:0] != 23'd0);
    b_nan    = (eb_q == EXP_MAX) && (mb_q[22:0] != 23'd0);
    a_inf    = (ea_q == EXP_MAX) && (ma_q[22:0] == 23'd0);
    b_inf    = (eb_q == EXP_MAX) && (mb_q[22:0] == 23'd0);
    a_zero   = (ea_q == 8'd0);
    b_zero   = (eb_q == 8'd0);
    a_larger = {ea_q, ma_q} >= {eb_q, mb_q};

    sign_l    = a_larger ? sa_q : sb_q;
    exp_l     = a_larger ? ea_q : eb_q;
    exp_s     = a_larger ? eb_q : ea_q;
    m_l       = a_larger ? ma_q : mb_q;
    m_s       = a_larger ? mb_q : ma_q;
    exp_diff  = exp_l - exp_s;
    s_aligned = (exp_diff >= 8'd26) ? 48'd0 : ({m_s, 24'd0} >> exp_diff);
    sum       = (sa_q == sb_q) ? ({1'b0, m_l, 24'd0} + {1'b0, s_aligned})
                               : ({1'b0, m_l, 24'd0} - {1'b0, s_aligned});
    product   = {24'd0, ma_q} * {24'd0, mb_q};

    // e_mant carries the value as mant/2^47 * 2^(e_exp - BIAS) for both operations.
    e_sign    = 1'b0;
    e_exp     = '0;
    e_mant    = '0;
    e_special = 1'b0;
    e_spec    = QNAN;
    case (op_q)
      OP_ADD: begin
        e_sign = sign_l;
        e_exp  = $signed({2'b00, exp_l}) + 10'sd1;
        e_mant = 48'(sum >> 1);
        if (a_nan || b_nan || (a_inf && b_inf && (sa_q != sb_q))) begin
          e_special = 1'b1;
          e_spec    = QNAN;
        end else if (a_inf) begin
          e_special = 1'b1;
          e_spec    = {sa_q, EXP_MAX, 23'd0};
        end else if (b_inf) begin
          e_special = 1'b1;
          e_spec    = {sb_q, EXP_MAX, 23'd0};
        end
      end
      OP_MUL: begin
        e_sign = sa_q ^ sb_q;
        e_exp  = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - BIAS + 10'sd1;
        e_mant = product;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
          e_special = 1'b1;
          e_spec    = QNAN;
        end else if (a_inf || b_inf) begin
          e_special = 1'b1;
          e_spec    = {e_sign, EXP_MAX, 23'd0};
        end else if (a_zero || b_zero) begin
          e_special = 1'b1;
          e_spec    = {e_sign, 31'd0};
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_sign_q    <= 1'b0;
      x_exp_q     <= '0;
      x_mant_q    <= '0;
      x_special_q <= 1'b0;
      x_spec_q    <= '0;
    end else if (state == S_EXEC) begin
      x_sign_q    <= e_sign;
      x_exp_q     <= e_exp;
      x_mant_q    <= e_mant;
      x_special_q <= e_special;
      x_spec_q    <= e_spec;
    end
  end

  logic [5:0]         lz;
  logic signed [9:0]  n_exp;
  logic [22:0]        n_frac;
  logic [31:0]        n_result;

  fp_lzc u_lzc (
    .value (x_mant_q),
    .count (lz)
  );

  // A zero magnitude always yields +0, which also covers exact add cancellation.
  always_comb begin
    n_exp  = x_exp_q - $signed({4'b0000, lz});
    n_frac = 23'((x_mant_q << lz) >> 24);
    if (x_special_q)
      n_result = x_spec_q;
    else if (x_mant_q == 48'd0)
      n_result = 32'd0;
    else if (n_exp >= $signed({2'b00, EXP_MAX}))
      n_result = {x_sign_q, EXP_MAX, 23'd0};
    else if (n_exp <= 10'sd0)
      n_result = {x_sign_q, 31'd0};
    else
      n_result = {x_sign_q, n_exp[7:0], n_frac};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                Result <= '0;
    else if (state == S_NORM)  Result <= n_result;
  end

endmodule

// File: tb/tb_fp_mc_unit.sv
// Directed self-checking bench for fp_mc_unit: latency, arithmetic, specials, handshake, reset.
module tb_fp_mc_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        ALUControl = 1'b0;
  logic        busy, done;
  logic [31:0] Result;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] exp;
  } vec_t;

  fp_mc_unit dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .a          (a),
    .b          (b),
    .ALUControl (ALUControl),
    .busy       (busy),
    .done       (done),
    .Result     (Result)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Returns at the falling edge of the first cycle after acceptance (cycle 1).
  task automatic issue(input logic [31:0] va, input logic [31:0] vb, input logic vop);
    @(negedge clk);
    start = 1'b1; a = va; b = vb; ALUControl = vop;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    int cyc;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (Result !== 32'h0) begin fails++; $display("[TB] FAIL reset_result: got %h expected 00000000", Result); end
    // Release reset and request in the same cycle: first edge must accept.
    reset = 1'b1; start = 1'b1; a = 32'h3F800000; b = 32'h40000000; ALUControl = 1'b0;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL first_accept_busy: got %b expected 1", busy); end
    wait_done(cyc);
    checks++; if (cyc != 4) begin fails++; $display("[TB] FAIL first_latency: got %0d expected 4", cyc); end
    checks++; if (Result !== 32'h40400000) begin fails++; $display("[TB] FAIL first_result: got %h expected 40400000", Result); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL done_pulse_width: got %b expected 0", done); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
    checks++; if (Result !== 32'h40400000) begin fails++; $display("[TB] FAIL result_hold: got %h expected 40400000", Result); end
  endtask

  task automatic test_add();
    int cyc;
    vec_t v[7] = '{
      '{32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000},
      '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000},
      '{32'h40400000, 32'hBF800000, 1'b0, 32'h40000000},
      '{32'hBF800000, 32'h3F000000, 1'b0, 32'hBF000000},
      '{32'h00000000, 32'hC0A00000, 1'b0, 32'hC0A00000},
      '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000},
      '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000}
    };
    for (int i = 0; i < 7; i++) begin
      issue(v[i].a, v[i].b, v[i].op);
      wait_done(cyc);
      checks++; if (cyc != 4) begin fails++; $display("[TB] FAIL add[%0d] latency: got %0d expected 4", i, cyc); end
      checks++; if (Result !== v[i].exp) begin fails++; $display("[TB] FAIL add[%0d] result: got %h expected %h", i, Result, v[i].exp); end
    end
  endtask

  task automatic test_mul();
    int cyc;
    vec_t v[7] = '{
      '{32'h40400000, 32'hC0000000, 1'b1, 32'hC0C00000},
      '{32'h3FC00000, 32'h40000000, 1'b1, 32'h40400000},
      '{32'h7F000000, 32'h40000000, 1'b1, 32'h7F800000},
      '{32'h00800000, 32'h00800000, 1'b1, 32'h00000000},
      '{32'h80800000, 32'h00800000, 1'b1, 32'h80000000},
      '{32'h00000000, 32'hC0000000, 1'b1, 32'h80000000},
      '{32'h40000000, 32'h40000000, 1'b1, 32'h40800000}
    };
    for (int i = 0; i < 7; i++) begin
      issue(v[i].a, v[i].b, v[i].op);
      wait_done(cyc);
      checks++; if (cyc != 4) begin fails++; $display("[TB] FAIL mul[%0d] latency: got %0d expected 4", i, cyc); end
      checks++; if (Result !== v[i].exp) begin fails++; $display("[TB] FAIL mul[%0d] result: got %h expected %h", i, Result, v[i].exp); end
    end
  endtask

  task automatic test_special();
    int cyc;
    vec_t v[6] = '{
      '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000},
      '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000},
      '{32'hFF800000, 32'hFF800000, 1'b0, 32'hFF800000},
      '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000},
      '{32'h7F800000, 32'h00000000, 1'b1, 32'h7FC00000},
      '{32'h7F800000, 32'hC0000000, 1'b1, 32'hFF800000}
    };
    for (int i = 0; i < 6; i++) begin
      issue(v[i].a, v[i].b, v[i].op);
      wait_done(cyc);
      checks++; if (Result !== v[i].exp) begin fails++; $display("[TB] FAIL special[%0d] result: got %h expected %h", i, Result, v[i].exp); end
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    @(negedge clk);
    start = 1'b1; a = 32'h40400000; b = 32'hC0000000; ALUControl = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c == 15) start = 1'b0;
      checks++;
      if (done !== ((c % 5) == 4)) begin
        fails++; $display("[TB] FAIL b2b_done cycle %0d: got %b expected %b", c, done, ((c % 5) == 4));
      end
      if (done === 1'b1) begin
        pulses++;
        checks++; if (Result !== 32'hC0C00000) begin fails++; $display("[TB] FAIL b2b_result: got %h expected c0c00000", Result); end
      end
    end
    checks++; if (pulses != 3) begin fails++; $display("[TB] FAIL b2b_pulses: got %0d expected 3", pulses); end
  endtask

  task automatic test_ignore_start();
    issue(32'h3FC00000, 32'h40000000, 1'b1);
    @(negedge clk);
    start = 1'b1; a = 32'h3F800000; b = 32'h3F800000; ALUControl = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b1) begin fails++; $display("[TB] FAIL ignore_exec_done: got %b expected 1", done); end
    checks++; if (Result !== 32'h40400000) begin fails++; $display("[TB] FAIL ignore_exec_result: got %h expected 40400000", Result); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL ignore_done_busy: got %b expected 0", busy); end
    checks++; if (Result !== 32'h40400000) begin fails++; $display("[TB] FAIL ignore_done_result: got %h expected 40400000", Result); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int seen = 0;
    issue(32'h3F800000, 32'h40000000, 1'b0);
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL mid_busy_before: got %b expected 1", busy); end
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL mid_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL mid_done: got %b expected 0", done); end
    checks++; if (Result !== 32'h0) begin fails++; $display("[TB] FAIL mid_result: got %h expected 00000000", Result); end
    @(negedge clk);
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin fails++; $display("[TB] FAIL mid_no_done: got %0d expected 0", seen); end
    checks++; if (Result !== 32'h0) begin fails++; $display("[TB] FAIL mid_result_after: got %h expected 00000000", Result); end
    issue(32'h40000000, 32'h40000000, 1'b1);
    wait_done(cyc);
    checks++; if (cyc != 4) begin fails++; $display("[TB] FAIL mid_recover_latency: got %0d expected 4", cyc); end
    checks++; if (Result !== 32'h40800000) begin fails++; $display("[TB] FAIL mid_recover_result: got %h expected 40800000", Result); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_special();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/fp_mc_unit.md
FP_MC_UNIT -- requirements
Module: fp_mc_unit

Interface
REQ-001 SHALL have no parameters; the operand width is fixed at 32 bits (IEEE-754 single precision).
REQ-002 SHALL have port `clk`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port `reset`, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port `start`, input, 1 bit: request; sampled only in IDLE.
REQ-005 SHALL have port `a`, input, 32 bits: operand A; captured when `start` is accepted.
REQ-006 SHALL have port `b`, input, 32 bits: operand B; captured when `start` is accepted.
REQ-007 SHALL have port `ALUControl`, input, 1 bit: operation select; 0 = add, 1 = multiply; captured when `start` is accepted.
REQ-008 SHALL have port `busy`, output, 1 bit: high from the cycle after acceptance through the DONE cycle.
REQ-009 SHALL have port `done`, output, 1 bit: a single-cycle pulse in DONE.
REQ-010 SHALL have port `Result`, output, 32 bits: IEEE-754 result; valid when `done` is high, then held until the next acceptance.

Function
REQ-011 SHALL implement a five-state FSM IDLE -> UNPACK -> EXEC -> NORM -> DONE -> IDLE, advancing unconditionally after IDLE.
REQ-012 SHALL accept a request when `start` is 1 in IDLE, and SHALL capture `a`, `b` and `ALUControl` on that same edge.
REQ-013 SHALL have a fixed latency: `done` = 1 exactly 4 cycles after the acceptance edge.
REQ-014 SHALL ignore `start` in every state other than IDLE; this includes DONE, so back-to-back requests are spaced 5 cycles apart.
REQ-015 UNPACK SHALL split the operands into sign, 8-bit exponent and 24-bit significand with the hidden bit; an exponent of 0 SHALL be treated as zero, so subnormals flush to zero.
REQ-016 EXEC for add SHALL:
- align the smaller-exponent significand by right-shifting it by the exponent difference (difference >= 26 makes it zero);
- add when the signs are equal, otherwise subtract the smaller magnitude from the larger;
- take the sign of the larger magnitude.
REQ-017 EXEC for multiply SHALL:
- compute the sign as sA XOR sB;
- compute the exponent as eA + eB - 127 with 10-bit signed intermediate;
- form the 48-bit significand product.
REQ-018 NORM SHALL normalize with a single-cycle leading-one detect and shift, and SHALL round toward zero (truncate).
REQ-019 An exact-zero add result SHALL be +0 (0x00000000).
REQ-020 Exponent overflow (>= 255) SHALL give signed infinity; underflow (<= 0) SHALL give signed zero.
REQ-021 Special operands SHALL be handled as follows:
- an operand with exponent 255 and nonzero fraction gives 0x7FC00000;
- inf + (-inf) gives 0x7FC00000;
- inf * 0 gives 0x7FC00000;
- otherwise, an infinite operand gives correctly signed infinity.
REQ-022 `Result` SHALL update only on the NORM -> DONE edge.

Reset
REQ-023 While `reset` = 0, the block SHALL asynchronously force: state = IDLE, `busy` = 0, `done` = 0, `Result` = 0x00000000, all operand registers = 0.
REQ-024 Reset mid-operation SHALL abort the operation with no `done` pulse.
REQ-025 The first acceptance SHALL be possible on the first rising edge after `reset` deasserts.

Structure
REQ-026 A shared package fp_pkg SHALL hold:
- the state enum;
- the constants BIAS = 127, EXP_MAX = 255, QNAN = 0x7FC00000;
- the op-select encodings OP_ADD = 0, OP_MUL = 1.
REQ-027 A sub-module fp_lzc SHALL implement the combinational 48-bit leading-zero count used in NORM; no other sub-modules SHALL be used.

Verification
REQ-028 Add: a = 0x3F800000, b = 0x40000000, ALUControl = 0 -> `Result` = 0x40400000 with `done` on cycle 4.
REQ-029 Multiply: a = 0x40400000, b = 0xC0000000, ALUControl = 1 -> `Result` = 0xC0C00000; a = 0x3FC00000, b = 0x40000000 -> `Result` = 0x40400000.
REQ-030 Cancellation and truncation: 0x3F800000 + 0xBF800000 -> 0x00000000; 0x3F800000 + 0x33800000 -> 0x3F800000.
REQ-031 Overflow and special operands: multiply 0x7F000000 * 0x40000000 -> 0x7F800000; 0x7F800000 + 0xFF800000 -> 0x7FC00000.
REQ-032 Handshake: `start` held high continuously -> `done` pulses every 5 cycles; a `start` pulse in EXEC with new operands is ignored and `Result` matches the original request.
REQ-033 Reset: `reset` = 0 asserted in NORM -> `busy` = 0 and `Result` = 0 immediately; no `done`; the next request completes normally.
